// File: rtl/clkdiv_pkg.sv
// Shared definitions for the multi-channel clock divider.
package clkdiv_pkg;

    localparam int unsigned MIN_HALF = 1;

    // Index width that never collapses to zero bits for a single channel.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, toggle flop, tick, and shadow/active half-period with pending flag.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int unsigned CW       = 24,
    parameter int unsigned DEF_HALF = 1
) (
    input  logic          clk_i,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic          sync_i,
    input  logic          we_i,
    input  logic [CW-1:0] half_i,
    output logic          clk_o,
    output logic          tick_o,
    output logic          pend_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] act_q, act_d;
    logic [CW-1:0] shd_q, shd_d;
    logic          clk_q, clk_d;
    logic          tick_q, tick_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] he;
    logic          wrap;

    // A zero half-period runs as the minimum so a channel can never stall.
    assign he   = (act_q == '0) ? CW'(MIN_HALF) : act_q;
    assign wrap = (cnt_q == he - CW'(1));

    always_comb begin
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        act_d  = act_q;
        shd_d  = shd_q;
        pend_d = pend_q;

        if (sync_i) begin
            cnt_d  = '0;
            clk_d  = 1'b0;
            act_d  = shd_q;
            pend_d = 1'b0;
        end else if (en_i) begin
            if (wrap) begin
                cnt_d  = '0;
                clk_d  = ~clk_q;
                tick_d = ~clk_q;
                // Falling toggle closes a full period: the only safe point to swap divisors.
                if (clk_q) begin
                    act_d  = shd_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // A write always wins the shadow, even on the cycle the old shadow is consumed.
        if (we_i) begin
            shd_d  = half_i;
            pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
            act_q  <= CW'(DEF_HALF);
            shd_q  <= CW'(DEF_HALF);
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
        end
    end

    assign clk_o  = clk_q;
    assign tick_o = tick_q;
    assign pend_o = pend_q;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider with glitch-free divisor updates and global sync.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter  int unsigned NCH      = 3,
    parameter  int unsigned CW       = 24,
    parameter  int unsigned DEF_HALF = 1,
    localparam int unsigned IW       = clog2_min1(NCH)
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [NCH-1:0] en,
    input  logic           sync,
    input  logic           cfg_we,
    input  logic [IW-1:0]  cfg_ch,
    input  logic [CW-1:0]  cfg_half,
    output logic [NCH-1:0] clk_out,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] cfg_pending
);

    logic [31:0]    ch_idx;
    logic           ch_ok;
    logic [NCH-1:0] ch_we;

    assign ch_idx = 32'(cfg_ch);
    // Indices past the last channel are dropped rather than aliased.
    assign ch_ok  = cfg_we && (ch_idx < NCH);

    always_comb begin
        ch_we = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            ch_we[i] = ch_ok && (ch_idx == i);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clkdiv_chan #(
            .CW       (CW),
            .DEF_HALF (DEF_HALF)
        ) u_chan (
            .clk_i  (clk),
            .clr_i  (clr),
            .en_i   (en[i]),
            .sync_i (sync),
            .we_i   (ch_we[i]),
            .half_i (cfg_half),
            .clk_o  (clk_out[i]),
            .tick_o (tick[i]),
            .pend_o (cfg_pending[i])
        );
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Directed bench for clkdiv_multi (NCH=3, CW=8, DEF_HALF=1) with hand-computed per-cycle vectors.
module tb_clkdiv_multi;

    logic       clk = 1'b0;
    logic       clr;
    logic [2:0] en;
    logic       sync;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [7:0] cfg_half;
    logic [2:0] clk_out;
    logic [2:0] tick;
    logic [2:0] cfg_pending;

    int checks = 0;
    int errors = 0;

    clkdiv_multi #(
        .NCH      (3),
        .CW       (8),
        .DEF_HALF (1)
    ) dut (
        .clk         (clk),
        .clr         (clr),
        .en          (en),
        .sync        (sync),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_half    (cfg_half),
        .clk_out     (clk_out),
        .tick        (tick),
        .cfg_pending (cfg_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] eclk, input logic [2:0] etick,
                       input logic [2:0] epend);
        checks++;
        assert (clk_out === eclk) else begin
            errors++;
            $error("FAIL %s clk_out: got %b want %b", tag, clk_out, eclk);
        end
        checks++;
        assert (tick === etick) else begin
            errors++;
            $error("FAIL %s tick: got %b want %b", tag, tick, etick);
        end
        checks++;
        assert (cfg_pending === epend) else begin
            errors++;
            $error("FAIL %s cfg_pending: got %b want %b", tag, cfg_pending, epend);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [7:0] h);
        cfg_we   = 1'b1;
        cfg_ch   = ch;
        cfg_half = h;
    endtask

    initial begin
        clr = 1'b1; en = 3'b000; sync = 1'b0; cfg_we = 1'b0; cfg_ch = 2'd0; cfg_half = 8'd0;
        @(posedge clk); #2;
        chk("rst_hold", 3'b000, 3'b000, 3'b000);
        @(negedge clk);
        clr = 1'b0; en = 3'b111;

        // Default half-period 1: every channel toggles each cycle.
        step(); chk("run1", 3'b111, 3'b111, 3'b000);
        step(); chk("run2", 3'b000, 3'b000, 3'b000);
        step(); chk("run3", 3'b111, 3'b111, 3'b000);
        step(); chk("run4", 3'b000, 3'b000, 3'b000);
        step(); chk("run5", 3'b111, 3'b111, 3'b000);

        // ch1 <- 3 while high; lands on its falling edge, so one more H=1 period first.
        cfg(2'd1, 8'd3); step(); cfg_we = 1'b0;
        chk("upd_wr", 3'b000, 3'b000, 3'b010);
        step(); chk("upd_hi", 3'b111, 3'b111, 3'b010);
        step(); chk("upd_apply", 3'b000, 3'b000, 3'b000);
        step(); chk("upd_l1", 3'b101, 3'b101, 3'b000);
        step(); chk("upd_l2", 3'b000, 3'b000, 3'b000);
        step(); chk("upd_h1", 3'b111, 3'b111, 3'b000);
        step(); chk("upd_h2", 3'b010, 3'b000, 3'b000);
        step(); chk("upd_h3", 3'b111, 3'b101, 3'b000);
        step(); chk("upd_l1b", 3'b000, 3'b000, 3'b000);
        step(); chk("upd_l2b", 3'b101, 3'b101, 3'b000);
        step(); chk("upd_l3b", 3'b000, 3'b000, 3'b000);
        step(); chk("upd_h1b", 3'b111, 3'b111, 3'b000);

        // Give ch2 shadow 2, then sync to make it active.
        cfg(2'd2, 8'd2); step(); cfg_we = 1'b0;
        chk("sim_pre", 3'b010, 3'b000, 3'b100);
        sync = 1'b1; step(); sync = 1'b0;
        chk("sim_sync", 3'b000, 3'b000, 3'b000);
        step(); chk("sim_a", 3'b001, 3'b001, 3'b000);
        step(); chk("sim_b", 3'b100, 3'b100, 3'b000);
        step(); chk("sim_c", 3'b111, 3'b011, 3'b000);
        // Write ch2 <- 4 on the same edge as its falling toggle.
        cfg(2'd2, 8'd4); step(); cfg_we = 1'b0;
        chk("sim_wr", 3'b010, 3'b000, 3'b100);
        step(); chk("sim_h2a", 3'b011, 3'b001, 3'b100);
        step(); chk("sim_h2b", 3'b100, 3'b100, 3'b100);
        step(); chk("sim_h2c", 3'b101, 3'b001, 3'b100);
        step(); chk("sim_apply", 3'b000, 3'b000, 3'b000);
        step(); chk("sim_h4a", 3'b011, 3'b011, 3'b000);
        step(); chk("sim_h4b", 3'b010, 3'b000, 3'b000);
        step(); chk("sim_h4c", 3'b011, 3'b001, 3'b000);
        step(); chk("sim_h4d", 3'b100, 3'b100, 3'b000);

        // ch0 <- 3 via sync, then freeze it mid-high with cnt=1.
        cfg(2'd0, 8'd3); step(); cfg_we = 1'b0;
        chk("frz_wr", 3'b101, 3'b001, 3'b001);
        sync = 1'b1; step(); sync = 1'b0;
        chk("frz_sync", 3'b000, 3'b000, 3'b000);
        step(); chk("frz_a", 3'b000, 3'b000, 3'b000);
        step(); chk("frz_b", 3'b000, 3'b000, 3'b000);
        step(); chk("frz_c", 3'b011, 3'b011, 3'b000);
        step(); chk("frz_d", 3'b111, 3'b100, 3'b000);
        en = 3'b110;
        step(); chk("frz_off1", 3'b111, 3'b000, 3'b000);
        step(); chk("frz_off2", 3'b101, 3'b000, 3'b000);
        step(); chk("frz_off3", 3'b101, 3'b000, 3'b000);
        step(); chk("frz_off4", 3'b001, 3'b000, 3'b000);
        step(); chk("frz_off5", 3'b011, 3'b010, 3'b000);
        en = 3'b111;
        step(); chk("frz_on1", 3'b011, 3'b000, 3'b000);
        step(); chk("frz_on2", 3'b010, 3'b000, 3'b000);
        step(); chk("frz_on3", 3'b100, 3'b100, 3'b000);

        // Program H = 1, 2, 5 and align with a one-cycle sync.
        cfg(2'd0, 8'd1); step(); chk("syn_w0", 3'b100, 3'b000, 3'b001);
        cfg(2'd1, 8'd2); step(); chk("syn_w1", 3'b101, 3'b001, 3'b011);
        cfg(2'd2, 8'd5); step(); chk("syn_w2", 3'b111, 3'b010, 3'b111);
        cfg_we = 1'b0;
        sync = 1'b1; step(); sync = 1'b0;
        chk("syn_pulse", 3'b000, 3'b000, 3'b000);
        step(); chk("syn_c1", 3'b001, 3'b001, 3'b000);
        step(); chk("syn_c2", 3'b010, 3'b010, 3'b000);
        step(); chk("syn_c3", 3'b011, 3'b001, 3'b000);
        step(); chk("syn_c4", 3'b000, 3'b000, 3'b000);
        step(); chk("syn_c5", 3'b101, 3'b101, 3'b000);

        // H=0 on ch0 and an out-of-range channel index.
        cfg(2'd0, 8'd0); step(); chk("edge_h0", 3'b110, 3'b010, 3'b001);
        cfg(2'd3, 8'd7); step(); chk("edge_oor", 3'b111, 3'b001, 3'b001);
        cfg_we = 1'b0;
        sync = 1'b1; step(); sync = 1'b0;
        chk("edge_sync", 3'b000, 3'b000, 3'b000);
        step(); chk("edge_c1", 3'b001, 3'b001, 3'b000);
        step(); chk("edge_c2", 3'b010, 3'b010, 3'b000);
        step(); chk("edge_c3", 3'b011, 3'b001, 3'b000);
        step(); chk("edge_c4", 3'b000, 3'b000, 3'b000);
        cfg(2'd1, 8'd9); step(); chk("edge_c5", 3'b101, 3'b101, 3'b010);
        cfg_we = 1'b0;

        // Asynchronous clear between clock edges.
        #2 clr = 1'b1;
        #1 chk("clr_async", 3'b000, 3'b000, 3'b000);
        @(negedge clk);
        chk("clr_hold", 3'b000, 3'b000, 3'b000);
        clr = 1'b0;
        step(); chk("clr_rel", 3'b111, 3'b111, 3'b000);
        step(); chk("clr_rel2", 3'b000, 3'b000, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
- Parametrised multi-channel clock divider, successor to the fixed-tap clkdiv.
- Each of NCH channels produces a 50%-duty divided clock and a one-cycle tick pulse, using its own runtime-programmable half-period.
- Divisor updates are glitch-free: a new value takes effect only at the end of a full output period.
- A sync input phase-aligns all channels. The block feeds display scanning, debouncers and slow-strobe logic from the single board clock.

Parameters:
- NCH, 3, number of divider channels (1..16).
- CW, 24, width of the per-channel counter and half-period value.
- DEF_HALF, 1, half-period (in clk cycles) loaded into every channel at reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- clr  in  1  asynchronous, active-high reset.
- en  in  NCH  per-channel run enable.
- sync  in  1  synchronous restart of all channels.
- cfg_we  in  1  write strobe for a new half-period.
- cfg_ch  in  max(1,$clog2(NCH))  target channel index.
- cfg_half  in  CW  new half-period H.
- clk_out  out  NCH  divided clocks, period 2*H clk cycles.
- tick  out  NCH  one-cycle pulse coincident with each clk_out rising edge.
- cfg_pending  out  NCH  shadow half-period written but not yet applied.

Behaviour:
- Reset (clr=1, asynchronous), per channel:
  - cnt=0, clk_out=0, tick=0, cfg_pending=0.
  - hp_active=DEF_HALF, hp_shadow=DEF_HALF.
- Effective half-period: He = (hp_active==0) ? 1 : hp_active. A value of 0 never stalls a channel.
- Counting, when en[i]=1 and sync=0:
  - If cnt != He-1: cnt increments.
  - If cnt == He-1: cnt<=0 and clk_out toggles.
- Tick:
  - tick[i]=1 in exactly the cycle in which clk_out[i] is first high; it is registered on the same edge as the 0->1 toggle.
  - tick is 0 otherwise, including when disabled.
- Update point: hp_active<=hp_shadow and cfg_pending<=0 only on a 1->0 toggle, i.e. at a full-period boundary. Mid-period writes never shorten or stretch the current period.
- Config write: cfg_we=1 with cfg_ch<NCH sets hp_shadow[cfg_ch]<=cfg_half and cfg_pending[cfg_ch]<=1. cfg_ch>=NCH is ignored with no state change.
- Write and update point in the same cycle:
  - hp_active takes the old shadow.
  - The new value lands in the shadow and cfg_pending stays 1.
  - The new value applies at the next period end.
- en[i]=0: cnt and clk_out freeze at their current values; tick=0. Pending writes still accumulate. Counting resumes from the frozen state.
- sync=1 (highest priority after clr), all channels regardless of en:
  - cnt<=0, clk_out<=0, tick<=0.
  - Pending shadows apply immediately: hp_active<=hp_shadow, cfg_pending<=0.
  - A cfg write in the same cycle still lands in the shadow and leaves pending=1.
- After sync or reset release, the first rising edge of clk_out[i] occurs He cycles later.
- clk_out is a register output, never gated combinationally. It is for logic enables and low-speed I/O only, not for clocking other flops.
- Latency: config write to visible effect is at most one full current period plus one cycle.

Decomposition:
- Shared package clkdiv_pkg:
  - Function clog2_min1 for the index width.
  - Constant MIN_HALF=1.
- One natural sub-module, clkdiv_chan: one channel's counter, toggle flop, tick, shadow/active registers and pending flag, with a per-channel cfg_we already decoded.
- The top instantiates NCH copies in a generate loop and performs cfg_ch decode and range check.

Test Plan:
- Reset/default, NCH=3, CW=8, DEF_HALF=1: clr pulse 10 ns, then en=3'b111. Required: all clk_out=0 during clr; afterwards each toggles every cycle (period 2); tick high every 2nd cycle aligned with clk_out rising.
- Glitch-free update: write ch1 H=3 while clk_out[1]=1. Required: cfg_pending[1]=1; current high and low phases complete with H=1; pending clears at the 1->0 edge; thereafter clk_out[1] is 3 high / 3 low. ch0 and ch2 are undisturbed.
- Simultaneous write/update: write ch2 H=4 in the cycle of ch2's 1->0 toggle, with shadow previously 2. Required: the next period uses H=2 and pending stays 1; the following period uses H=4.
- Enable freeze: drop en[0] for 5 cycles mid-high with H=3, cnt=1. Required: clk_out[0] stays 1 and tick[0]=0; after re-enable, 2 more high cycles, then low.
- Sync alignment: channels at H=1, 2, 5 with arbitrary phases; assert sync 1 cycle. Required: all clk_out=0, pending cleared; rising edges 1, 2 and 5 cycles later, with ticks at those cycles.
- Edge values: write H=0 to ch0 and cfg_ch=3 with H=7. Required: ch0 behaves as H=1; the out-of-range write changes no state; clr asserted mid-period forces all outputs to 0 immediately.
